// File: rtl/parking_gate_scheduler_pkg.sv
// parking_pkg: shared types and constants for the parking gate scheduler.
//   gate_state_t : scheduler FSM states
//   DIR_ENTRY / DIR_EXIT : gate_dir / last_served encoding
//   max2 : helper used to size the shared timer
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_AUTH,
    OPEN_IN,
    OPEN_OUT,
    CLOSE
  } gate_state_t;

  localparam logic DIR_ENTRY = 1'b0;
  localparam logic DIR_EXIT  = 1'b1;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/parking_gate_scheduler_if.sv
// parking_gate_scheduler_if: lane-side requests in, gate/status out.
//   master : lane sensors + password checker (drives requests)
//   slave  : the scheduler (drives gate and status)
// Requests : entry_req, entry_auth, exit_req, pass_sensor
// Status   : gate_open, gate_dir, busy, occupancy[CNT_W], full, empty,
//            auth_timeout, gate_timeout
interface parking_gate_scheduler_if #(
  parameter int CAPACITY = 8,
  parameter int CNT_W    = $clog2(CAPACITY + 1)
) ();

  logic             entry_req;
  logic             entry_auth;
  logic             exit_req;
  logic             pass_sensor;
  logic             gate_open;
  logic             gate_dir;
  logic             busy;
  logic [CNT_W-1:0] occupancy;
  logic             full;
  logic             empty;
  logic             auth_timeout;
  logic             gate_timeout;

  modport master (
    output entry_req, entry_auth, exit_req, pass_sensor,
    input  gate_open, gate_dir, busy, occupancy, full, empty,
           auth_timeout, gate_timeout
  );

  modport slave (
    input  entry_req, entry_auth, exit_req, pass_sensor,
    output gate_open, gate_dir, busy, occupancy, full, empty,
           auth_timeout, gate_timeout
  );

endinterface

// File: rtl/parking_gate_scheduler_timer.sv
// parking_gate_timer: up-counter shared by the auth wait and the open window.
//   clk, reset : clock, synchronous active-high reset
//   clr        : restart from 0 (asserted on every state change)
//   limit      : runtime window length in cycles (>= 1)
//   expired    : high during the limit-th cycle since the last clear
// The count saturates at limit-1 so it can never wrap while a state lingers.
module parking_gate_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] cnt_q;

  assign expired = (cnt_q == limit - W'(1));

  always_ff @(posedge clk) begin
    if (reset || clr)  cnt_q <= '0;
    else if (!expired) cnt_q <= cnt_q + W'(1);
  end

endmodule

// File: rtl/parking_gate_scheduler.sv
// parking_gate_scheduler: shares one barrier between entry and exit lanes and
// tracks lot occupancy against CAPACITY.
//   clk   : sole clock, rising edge
//   reset : synchronous, active-high
//   gif   : parking_gate_scheduler_if.slave (requests in, gate/status out)
// Entry needs an entry_auth pulse while in WAIT_AUTH; exit opens directly.
// Optional build macro: EXIT_PRIORITY_EN -- exit always wins a tie in IDLE
// (no round-robin state kept); otherwise ties alternate via last_served.
module parking_gate_scheduler
  import parking_pkg::*;
#(
  parameter int CAPACITY    = 8,
  parameter int OPEN_CYCLES = 50,
  parameter int AUTH_WAIT   = 100
) (
  input  logic                      clk,
  input  logic                      reset,
  parking_gate_scheduler_if.slave   gif
);

  localparam int CNT_W = $clog2(CAPACITY + 1);
  localparam int TW    = $clog2(max2(OPEN_CYCLES, AUTH_WAIT) + 1);

  gate_state_t      state_q, state_d;
  logic [CNT_W-1:0] occ_q;
  logic             gate_open_q, gate_dir_q, busy_q, ato_q, gto_q;
  logic             ato_d, gto_d, inc, dec;
  logic             full, empty, entry_ok, exit_ok, pick_exit;
  logic             t_clr, t_exp;
  logic [TW-1:0]    t_limit;

`ifndef EXIT_PRIORITY_EN
  logic             last_q;
`endif

  assign full     = (occ_q == CNT_W'(CAPACITY));
  assign empty    = (occ_q == '0);
  assign entry_ok = gif.entry_req && !full;
  assign exit_ok  = gif.exit_req && !empty;

`ifdef EXIT_PRIORITY_EN
  assign pick_exit = 1'b1;
`else
  // Serve whichever direction did not get the previous grant.
  assign pick_exit = (last_q == DIR_ENTRY);
`endif

  // One timer serves both waits; it runs only inside WAIT_AUTH/OPEN_* and
  // restarts on every state change.
  assign t_limit = (state_q == WAIT_AUTH) ? TW'(AUTH_WAIT) : TW'(OPEN_CYCLES);
  assign t_clr   = (state_d != state_q) || (state_q == IDLE) || (state_q == CLOSE);

  parking_gate_timer #(.W(TW)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (t_clr),
    .limit   (t_limit),
    .expired (t_exp)
  );

  always_comb begin
    state_d = state_q;
    ato_d   = 1'b0;
    gto_d   = 1'b0;
    inc     = 1'b0;
    dec     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (entry_ok && exit_ok) state_d = pick_exit ? OPEN_OUT : WAIT_AUTH;
        else if (entry_ok)       state_d = WAIT_AUTH;
        else if (exit_ok)        state_d = OPEN_OUT;
      end
      WAIT_AUTH: begin
        // Credential beats expiry; a car that drove off is not a timeout.
        if (gif.entry_auth)     state_d = OPEN_IN;
        else if (!gif.entry_req) state_d = IDLE;
        else if (t_exp) begin
          state_d = IDLE;
          ato_d   = 1'b1;
        end
      end
      OPEN_IN, OPEN_OUT: begin
        if (gif.pass_sensor) begin
          state_d = CLOSE;
          inc     = (state_q == OPEN_IN);
          dec     = (state_q == OPEN_OUT);
        end else if (t_exp) begin
          state_d = CLOSE;
          gto_d   = 1'b1;
        end
      end
      CLOSE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      occ_q       <= '0;
      gate_open_q <= 1'b0;
      gate_dir_q  <= DIR_ENTRY;
      busy_q      <= 1'b0;
      ato_q       <= 1'b0;
      gto_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gate_open_q <= (state_d == OPEN_IN) || (state_d == OPEN_OUT);
      busy_q      <= (state_d != IDLE);
      ato_q       <= ato_d;
      gto_q       <= gto_d;
      if (state_d == OPEN_IN)  gate_dir_q <= DIR_ENTRY;
      if (state_d == OPEN_OUT) gate_dir_q <= DIR_EXIT;
      // Counter saturates at both ends regardless of eligibility gating.
      if (inc && !full)       occ_q <= occ_q + CNT_W'(1);
      else if (dec && !empty) occ_q <= occ_q - CNT_W'(1);
    end
  end

`ifndef EXIT_PRIORITY_EN
  // A grant is any departure from IDLE.
  always_ff @(posedge clk) begin
    if (reset) last_q <= DIR_EXIT;
    else if (state_q == IDLE && state_d == WAIT_AUTH) last_q <= DIR_ENTRY;
    else if (state_q == IDLE && state_d == OPEN_OUT)  last_q <= DIR_EXIT;
  end
`endif

  assign gif.gate_open    = gate_open_q;
  assign gif.gate_dir     = gate_dir_q;
  assign gif.busy         = busy_q;
  assign gif.occupancy    = occ_q;
  assign gif.full         = full;
  assign gif.empty        = empty;
  assign gif.auth_timeout = ato_q;
  assign gif.gate_timeout = gto_q;

endmodule

// File: tb/tb_parking_gate_scheduler.sv
// Self-checking bench for parking_gate_scheduler (CAPACITY=2, OPEN_CYCLES=4,
// AUTH_WAIT=6). Output events (gate openings, occupancy changes, timeout
// pulses) are matched in order against a scoreboard queue filled by the
// stimulus; cycle-exact levels are checked directly.
module tb_parking_gate_scheduler;
  import parking_pkg::*;

  localparam int EV_OPEN = 16;
  localparam int EV_OCC  = 32;
  localparam int EV_ATO  = 48;
  localparam int EV_GTO  = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  parking_gate_scheduler_if #(.CAPACITY(2)) gif ();

  parking_gate_scheduler #(.CAPACITY(2), .OPEN_CYCLES(4), .AUTH_WAIT(6)) dut (
    .clk   (clk),
    .reset (reset),
    .gif   (gif)
  );

  int   checks = 0;
  int   failures = 0;
  int   sb_q[$];
  int   exp_occ = 0;
  bit   mon_en = 1'b0;
  logic prev_open = 1'b0;
  logic [1:0] prev_occ = '0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic sb_pop(input string tag, input int code);
    if (sb_q.size() == 0) chk({tag, "_unexpected"}, code, 0);
    else                  chk(tag, code, sb_q.pop_front());
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (gif.gate_open && !prev_open) sb_pop("ev_open", EV_OPEN + int'(gif.gate_dir));
      if (gif.occupancy != prev_occ)   sb_pop("ev_occ", EV_OCC + int'(gif.occupancy));
      if (gif.auth_timeout)            sb_pop("ev_ato", EV_ATO);
      if (gif.gate_timeout)            sb_pop("ev_gto", EV_GTO);
    end
    prev_open = gif.gate_open;
    prev_occ  = gif.occupancy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_entry();
    gif.entry_req = 1'b1;
    tick();
    chk("entry_busy", int'(gif.busy), 1);
    chk("entry_wait_closed", int'(gif.gate_open), 0);
    tick();
    tick();
    gif.entry_auth = 1'b1;
    sb_q.push_back(EV_OPEN + int'(DIR_ENTRY));
    tick();
    gif.entry_auth = 1'b0;
    gif.entry_req  = 1'b0;
    chk("entry_open", int'(gif.gate_open), 1);
    chk("entry_dir", int'(gif.gate_dir), 0);
    exp_occ++;
    sb_q.push_back(EV_OCC + exp_occ);
    gif.pass_sensor = 1'b1;
    tick();
    gif.pass_sensor = 1'b0;
    chk("entry_occ", int'(gif.occupancy), exp_occ);
    chk("entry_closed", int'(gif.gate_open), 0);
    tick();
    chk("entry_idle", int'(gif.busy), 0);
  endtask

  task automatic do_exit(input bit pass_on_expiry);
    gif.exit_req = 1'b1;
    sb_q.push_back(EV_OPEN + int'(DIR_EXIT));
    tick();
    gif.exit_req = 1'b0;
    chk("exit_open", int'(gif.gate_open), 1);
    chk("exit_dir", int'(gif.gate_dir), 1);
    if (pass_on_expiry) begin
      for (int i = 0; i < 3; i++) begin
        tick();
        chk("exit_hold_open", int'(gif.gate_open), 1);
      end
    end
    exp_occ--;
    sb_q.push_back(EV_OCC + exp_occ);
    gif.pass_sensor = 1'b1;
    tick();
    gif.pass_sensor = 1'b0;
    chk("exit_occ", int'(gif.occupancy), exp_occ);
    chk("exit_closed", int'(gif.gate_open), 0);
    chk("exit_no_gto", int'(gif.gate_timeout), 0);
    tick();
    chk("exit_idle", int'(gif.busy), 0);
  endtask

  // Both requests held; the granted side never passes, so occupancy stays put.
  task automatic serve_tie(input logic dir);
    sb_q.push_back(EV_OPEN + int'(dir));
    tick();
    if (dir == DIR_ENTRY) begin
      chk("tie_wait_busy", int'(gif.busy), 1);
      chk("tie_wait_closed", int'(gif.gate_open), 0);
      gif.entry_auth = 1'b1;
      tick();
      gif.entry_auth = 1'b0;
    end
    chk("tie_open", int'(gif.gate_open), 1);
    chk("tie_dir", int'(gif.gate_dir), int'(dir));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("tie_hold_open", int'(gif.gate_open), 1);
    end
    sb_q.push_back(EV_GTO);
    tick();
    chk("gto_closed", int'(gif.gate_open), 0);
    chk("gto_pulse", int'(gif.gate_timeout), 1);
    chk("gto_occ", int'(gif.occupancy), exp_occ);
    tick();
    chk("gto_idle", int'(gif.busy), 0);
    chk("gto_pulse_end", int'(gif.gate_timeout), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    gif.entry_req   = 1'b0;
    gif.entry_auth  = 1'b0;
    gif.exit_req    = 1'b0;
    gif.pass_sensor = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    mon_en = 1'b1;
    chk("rst_open", int'(gif.gate_open), 0);
    chk("rst_dir", int'(gif.gate_dir), 0);
    chk("rst_busy", int'(gif.busy), 0);
    chk("rst_occ", int'(gif.occupancy), 0);
    chk("rst_empty", int'(gif.empty), 1);
    chk("rst_full", int'(gif.full), 0);
    chk("rst_ato", int'(gif.auth_timeout), 0);
    chk("rst_gto", int'(gif.gate_timeout), 0);

    // Exit while empty is ignored.
    gif.exit_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("empty_exit_ignored", int'(gif.busy), 0);
    end
    gif.exit_req = 1'b0;
    tick();

    // Fill the lot, then a held entry is ignored.
    do_entry();
    do_entry();
    chk("full_flag", int'(gif.full), 1);
    chk("full_not_empty", int'(gif.empty), 0);
    gif.entry_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("full_entry_busy", int'(gif.busy), 0);
      chk("full_entry_closed", int'(gif.gate_open), 0);
    end
    gif.entry_req = 1'b0;
    tick();

    // Exit last, so the first tie at occupancy 1 favours entry.
    do_exit(1'b0);
    gif.entry_req = 1'b1;
    gif.exit_req  = 1'b1;
`ifdef EXIT_PRIORITY_EN
    serve_tie(DIR_EXIT);
    serve_tie(DIR_EXIT);
`else
    serve_tie(DIR_ENTRY);
    serve_tie(DIR_EXIT);
`endif
    gif.entry_req = 1'b0;
    gif.exit_req  = 1'b0;
    tick();

    // Auth timeout: six WAIT_AUTH cycles, then a pulse back in IDLE.
    gif.entry_req = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      chk("ato_wait_busy", int'(gif.busy), 1);
      chk("ato_wait_closed", int'(gif.gate_open), 0);
      chk("ato_early", int'(gif.auth_timeout), 0);
      if (i == 5) sb_q.push_back(EV_ATO);
      tick();
    end
    gif.entry_req = 1'b0;
    chk("ato_pulse", int'(gif.auth_timeout), 1);
    chk("ato_idle", int'(gif.busy), 0);
    chk("ato_closed", int'(gif.gate_open), 0);
    tick();
    chk("ato_pulse_end", int'(gif.auth_timeout), 0);
    chk("ato_occ", int'(gif.occupancy), 1);

    // Pass on the expiry cycle counts as a pass.
    do_exit(1'b1);
    chk("empty_flag", int'(gif.empty), 1);

    // Reset during OPEN_OUT with a full lot.
    do_entry();
    do_entry();
    gif.exit_req = 1'b1;
    sb_q.push_back(EV_OPEN + int'(DIR_EXIT));
    tick();
    gif.exit_req = 1'b0;
    chk("rst_pre_open", int'(gif.gate_open), 1);
    reset = 1'b1;
    exp_occ = 0;
    sb_q.push_back(EV_OCC + 0);
    tick();
    reset = 1'b0;
    chk("rst_mid_open", int'(gif.gate_open), 0);
    chk("rst_mid_busy", int'(gif.busy), 0);
    chk("rst_mid_occ", int'(gif.occupancy), 0);
    chk("rst_mid_empty", int'(gif.empty), 1);
    tick();
    chk("rst_after_busy", int'(gif.busy), 0);

    tick();
    chk("sb_drain", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parking_gate_scheduler.md
# parking_gate_scheduler

Shares a single barrier gate between the entry lane and the exit lane of the car park. Tracks lot occupancy against a fixed capacity. Entry needs a one-cycle credential-valid pulse from the password checker before the gate opens; exit opens directly. Sits between the lane sensors and password checker on one side and the gate actuator and status LEDs on the other.

## Interface
- CAPACITY, 8: number of bays; must be at least 1.
- OPEN_CYCLES, 50: maximum cycles the gate stays open waiting for the car to pass.
- AUTH_WAIT, 100: maximum cycles spent waiting for entry_auth.
- CNT_W, $clog2(CAPACITY+1): derived localparam, occupancy width.
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- entry_req  in  1  level; car present at entrance sensor.
- entry_auth  in  1  one-cycle pulse; credentials valid.
- exit_req  in  1  level; car present at exit sensor.
- pass_sensor  in  1  high when car has cleared the gate.
- gate_open  out  1  registered; barrier raised.
- gate_dir  out  1  registered; 0 = entry, 1 = exit.
- busy  out  1  registered; FSM not in IDLE.
- occupancy  out  CNT_W  registered; cars inside.
- full  out  1  occupancy == CAPACITY.
- empty  out  1  occupancy == 0.
- auth_timeout  out  1  one-cycle pulse; AUTH_WAIT expired.
- gate_timeout  out  1  one-cycle pulse; OPEN_CYCLES expired with no pass.

## Operation
- States: IDLE, WAIT_AUTH, OPEN_IN, OPEN_OUT, CLOSE.
- Eligibility:
  - Entry is eligible when entry_req && !full.
  - Exit is eligible when exit_req && !empty.
  - Ineligible requests are ignored; the FSM stays in IDLE.
- IDLE:
  - Only entry eligible → WAIT_AUTH.
  - Only exit eligible → OPEN_OUT.
  - Both eligible → round-robin: serve the direction not recorded in last_served.
  - last_served updates on every grant.
- WAIT_AUTH:
  - entry_auth → OPEN_IN.
  - entry_req low → IDLE.
  - Timer reaches AUTH_WAIT → IDLE and pulse auth_timeout.
  - entry_auth wins over simultaneous expiry.
- OPEN_IN / OPEN_OUT:
  - gate_open=1; gate_dir=0 or 1 respectively.
  - pass_sensor → occupancy +1 (entry) or −1 (exit), then CLOSE.
  - Timer reaches OPEN_CYCLES with no pass → CLOSE, pulse gate_timeout, occupancy unchanged.
  - pass_sensor and timer expiry in the same cycle count as a pass.
- CLOSE: exactly one cycle with gate_open=0 and timer cleared; → IDLE.
- Occupancy guards: the counter never wraps. An increment at CAPACITY or a decrement at 0 is suppressed, in addition to the eligibility gating.
- Timer: restarts at 0 on every state entry.
- Reset values:
  - State IDLE, timer 0, occupancy 0.
  - last_served = exit, so entry wins the first tie.
  - gate_open 0, gate_dir 0, busy 0, full 0, empty 1, both timeout pulses 0.

## Timing
- All outputs are registered, except full and empty, which decode the occupancy register.
- Request sampled in IDLE at edge N:
  - busy=1 from N+1.
  - Exit: gate_open=1 from N+1.
  - Entry: gate_open=1 one cycle after the edge that samples entry_auth.
- pass_sensor sampled at edge M: occupancy updated and gate_open=0 from M+1; IDLE at M+2.
- Minimum back-to-back service: one CLOSE cycle between consecutive gate openings.
- Reset asserted in any state: at the next edge all state and outputs take their reset values. An in-flight car is not counted.

## Configuration
- EXIT_PRIORITY_EN defined:
  - Exit always wins a tie in IDLE.
  - last_served is neither used nor updated.
- EXIT_PRIORITY_EN undefined: round-robin as described in Operation.

## Structure
- parking_pkg holds:
  - Enum gate_state_t (IDLE, WAIT_AUTH, OPEN_IN, OPEN_OUT, CLOSE).
  - Constants DIR_ENTRY=1'b0 and DIR_EXIT=1'b1.
- One sub-module, parking_gate_timer:
  - Synchronous up-counter with clear and a compare against a runtime limit.
  - Emits an expired flag.
  - Width $clog2(max(OPEN_CYCLES, AUTH_WAIT)+1).

## Test plan
Bench parameters: CAPACITY=2, OPEN_CYCLES=4, AUTH_WAIT=6.
- Entry: entry_req=1, then entry_auth pulse 2 cycles later, then pass_sensor pulse → gate_open=1 with gate_dir=0 the cycle after auth; occupancy=1 and gate_open=0 the cycle after pass; busy=0 after CLOSE.
- Full: two successful entries → occupancy=2, full=1; a further entry_req held 10 cycles → state stays IDLE, busy=0, gate_open=0.
- Tie, occupancy=1:
  - After reset, entry_req and exit_req together → entry served first, then exit.
  - Repeat the tie → exit first.
  - With EXIT_PRIORITY_EN → exit first every time.
- Auth timeout: entry_req held with no entry_auth → auth_timeout pulses on the 6th WAIT_AUTH cycle; return to IDLE; occupancy unchanged; gate never opens.
- Gate timeout:
  - Exit granted, no pass_sensor → gate_timeout pulse after 4 open cycles; gate closes; occupancy unchanged.
  - pass_sensor on the expiry cycle → occupancy decremented and no gate_timeout pulse.
- Reset: reset=1 for one cycle during OPEN_OUT with occupancy=2 → next cycle gate_open=0, busy=0, occupancy=0, empty=1.
